// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared ALU function bits, writeback-select bits, FSM encoding
//            and the writeback source mux for the execute/memory/writeback stage.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int c_XLEN     = 32;
  localparam int c_FUN_W    = 19;
  localparam int c_WB_SEL_W = 3;

  // exe_fun one-hot bit positions
  localparam int c_FUN_ADD   = 18;
  localparam int c_FUN_SUB   = 17;
  localparam int c_FUN_AND   = 16;
  localparam int c_FUN_OR    = 15;
  localparam int c_FUN_XOR   = 14;
  localparam int c_FUN_SLL   = 13;
  localparam int c_FUN_SRL   = 12;
  localparam int c_FUN_SRA   = 11;
  localparam int c_FUN_SLT   = 10;
  localparam int c_FUN_SLTU  = 9;
  localparam int c_FUN_BEQ   = 8;
  localparam int c_FUN_BNE   = 7;
  localparam int c_FUN_BGE   = 6;
  localparam int c_FUN_BGEU  = 5;
  localparam int c_FUN_BLT   = 4;
  localparam int c_FUN_BLTU  = 3;
  localparam int c_FUN_JALR  = 2;
  localparam int c_FUN_COPY1 = 1;
  localparam int c_FUN_X     = 0;

  // wb_sel bit positions; all-zero selects the ALU result
  localparam int c_WB_MEM = 2;
  localparam int c_WB_PC  = 1;
  localparam int c_WB_CSR = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_WAIT = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  function automatic logic [c_XLEN-1:0] wb_mux(
    input logic [c_WB_SEL_W-1:0] sel,
    input logic [c_XLEN-1:0]     load_data,
    input logic [c_XLEN-1:0]     pc,
    input logic [c_XLEN-1:0]     alu_res
  );
    if (sel[c_WB_MEM])      return load_data;
    else if (sel[c_WB_PC])  return pc + 32'd4;
    else if (sel[c_WB_CSR]) return alu_res;
    else                    return alu_res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Brief    : Combinational ALU with one-hot function select; produces the
//            arithmetic result and the branch condition.
// Revision : 1.0 - initial release
// ============================================================================
module alu
  import riscv_pkg::*;
(
  input  logic [c_XLEN-1:0]  op1,
  input  logic [c_XLEN-1:0]  op2,
  input  logic [c_FUN_W-1:0] exe_fun,
  output logic [c_XLEN-1:0]  result,
  output logic               cond
);

  logic [4:0]        w_shamt;
  logic [c_XLEN-1:0] w_sum;
  logic              w_eq;
  logic              w_lt_s;
  logic              w_lt_u;

  assign w_shamt = op2[4:0];
  assign w_sum   = op1 + op2;
  assign w_eq    = (op1 == op2);
  assign w_lt_s  = ($signed(op1) < $signed(op2));
  assign w_lt_u  = (op1 < op2);

  always_comb begin
    result = '0;
    if (exe_fun[c_FUN_ADD])        result = w_sum;
    else if (exe_fun[c_FUN_SUB])   result = op1 - op2;
    else if (exe_fun[c_FUN_AND])   result = op1 & op2;
    else if (exe_fun[c_FUN_OR])    result = op1 | op2;
    else if (exe_fun[c_FUN_XOR])   result = op1 ^ op2;
    else if (exe_fun[c_FUN_SLL])   result = op1 << w_shamt;
    else if (exe_fun[c_FUN_SRL])   result = op1 >> w_shamt;
    else if (exe_fun[c_FUN_SRA])   result = $unsigned($signed(op1) >>> w_shamt);
    else if (exe_fun[c_FUN_SLT])   result = {{(c_XLEN-1){1'b0}}, w_lt_s};
    else if (exe_fun[c_FUN_SLTU])  result = {{(c_XLEN-1){1'b0}}, w_lt_u};
    else if (exe_fun[c_FUN_JALR])  result = {w_sum[c_XLEN-1:1], 1'b0};
    else if (exe_fun[c_FUN_COPY1]) result = op1;
    else if (exe_fun[c_FUN_X])     result = '0;
  end

  // Branch ops leave result at zero; only the condition is meaningful
  always_comb begin
    cond = (exe_fun[c_FUN_BEQ]  &  w_eq)   |
           (exe_fun[c_FUN_BNE]  & ~w_eq)   |
           (exe_fun[c_FUN_BGE]  & ~w_lt_s) |
           (exe_fun[c_FUN_BGEU] & ~w_lt_u) |
           (exe_fun[c_FUN_BLT]  &  w_lt_s) |
           (exe_fun[c_FUN_BLTU] &  w_lt_u);
  end

endmodule
`default_nettype wire

// File: rtl/exe_mem_wb.sv
`default_nettype none
// ============================================================================
// Module   : exe_mem_wb
// Brief    : Execute / data-memory / writeback stage, one bundle at a time.
//            Define MISALIGN_CHK_EN to trap misaligned memory accesses.
// Revision : 1.0 - initial release
// ============================================================================
module exe_mem_wb
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [c_XLEN-1:0]     pc_in,
  input  logic [c_XLEN-1:0]     op1_data,
  input  logic [c_XLEN-1:0]     op2_data,
  input  logic [c_XLEN-1:0]     st_data,
  input  logic [4:0]            rd_in,
  input  logic                  rd_wen_in,
  input  logic [c_FUN_W-1:0]    exe_fun,
  input  logic                  mem_we,
  input  logic                  mem_re,
  input  logic [c_WB_SEL_W-1:0] wb_sel,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [c_XLEN-1:0]     dmem_addr,
  output logic [c_XLEN-1:0]     dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [c_XLEN-1:0]     dmem_rdata,
  output logic [4:0]            wb_addr,
  output logic                  wb_we,
  output logic [c_XLEN-1:0]     wb_data,
  output logic                  br_taken,
  output logic                  misalign
);

  state_t                  r_state;
  logic [c_XLEN-1:0]       r_pc;
  logic [c_XLEN-1:0]       r_alu;
  logic [c_XLEN-1:0]       r_st_data;
  logic [c_XLEN-1:0]       r_load_data;
  logic [c_XLEN-1:0]       r_wb_data;
  logic [4:0]              r_rd;
  logic [c_WB_SEL_W-1:0]   r_wb_sel;
  logic                    r_wb_en;
  logic                    r_cond;
  logic                    r_is_store;
  logic                    r_dmem_req;
  logic                    r_wb_we;
  logic                    r_br_taken;
  logic                    r_misalign;

  logic [c_XLEN-1:0]       w_alu_result;
  logic                    w_alu_cond;
  logic                    w_is_mem;
  logic                    w_wb_en;
  logic                    w_misaligned;

  alu u_alu (
    .op1     (op1_data),
    .op2     (op2_data),
    .exe_fun (exe_fun),
    .result  (w_alu_result),
    .cond    (w_alu_cond)
  );

  assign w_is_mem = mem_we | mem_re;
  assign w_wb_en  = rd_wen_in && (rd_in != 5'd0);

`ifdef MISALIGN_CHK_EN
  assign w_misaligned = w_is_mem && (w_alu_result[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_alu       <= '0;
      r_st_data   <= '0;
      r_load_data <= '0;
      r_wb_data   <= '0;
      r_rd        <= '0;
      r_wb_sel    <= '0;
      r_wb_en     <= 1'b0;
      r_cond      <= 1'b0;
      r_is_store  <= 1'b0;
      r_dmem_req  <= 1'b0;
      r_wb_we     <= 1'b0;
      r_br_taken  <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      r_wb_we    <= 1'b0;
      r_br_taken <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (id_valid) begin
            r_pc        <= pc_in;
            r_alu       <= w_alu_result;
            r_st_data   <= st_data;
            r_rd        <= rd_in;
            r_wb_sel    <= wb_sel;
            r_wb_en     <= w_wb_en;
            r_cond      <= w_alu_cond;
            r_is_store  <= mem_we;
            r_load_data <= '0;
            if (w_misaligned) begin
              r_state    <= ST_WB;
              r_misalign <= 1'b1;
            end else if (w_is_mem) begin
              r_state    <= ST_MEM;
              r_dmem_req <= 1'b1;
            end else begin
              r_state    <= ST_WB;
              r_wb_we    <= w_wb_en;
              r_br_taken <= w_alu_cond;
              r_wb_data  <= wb_mux(wb_sel, '0, pc_in, w_alu_result);
            end
          end
        end
        ST_MEM: begin
          if (dmem_gnt) begin
            r_dmem_req <= 1'b0;
            // mem_we wins over mem_re, so a latched store never waits for data
            if (r_is_store) begin
              r_state    <= ST_WB;
              r_wb_we    <= r_wb_en;
              r_br_taken <= r_cond;
              r_wb_data  <= wb_mux(r_wb_sel, r_load_data, r_pc, r_alu);
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (dmem_rvalid) begin
            r_load_data <= dmem_rdata;
            r_state     <= ST_WB;
            r_wb_we     <= r_wb_en;
            r_br_taken  <= r_cond;
            r_wb_data   <= wb_mux(r_wb_sel, dmem_rdata, r_pc, r_alu);
          end
        end
        ST_WB:   r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Gated with rst_n so the handshake is closed while reset is held
  assign id_ready   = (r_state == ST_IDLE) && rst_n;
  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_is_store;
  assign dmem_addr  = r_alu;
  assign dmem_wdata = r_st_data;
  assign wb_addr    = r_rd;
  assign wb_we      = r_wb_we;
  assign wb_data    = r_wb_data;
  assign br_taken   = r_br_taken;
  assign misalign   = r_misalign;

endmodule
`default_nettype wire
